// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared state encoding and constants
// for the two-requester flash read arbiter.
package flash_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } state_e;

   localparam int         ADDR_W_DEF = 23;
   localparam int         DATA_W_DEF = 32;
   localparam logic [3:0] BYTEEN_ALL = 4'b1111;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/flash_read_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
// A tie goes to the requester that was not served last.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   always_comb begin
      gnt_valid_o = |req_i;
      unique case (req_i)
         2'b01:   gnt_idx_o = 1'b0;
         2'b10:   gnt_idx_o = 1'b1;
         2'b11:   gnt_idx_o = ~last_grant_i;
         default: gnt_idx_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one Avalon-MM flash read port between
// two requesters, one read outstanding, with a readdatavalid timeout.
module flash_read_arbiter
   import flash_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_read,
   input  logic [2*ADDR_W-1:0] req_address,
   output logic [1:0]          req_waitrequest,
   output logic [DATA_W-1:0]   req_readdata,
   output logic [1:0]          req_readdatavalid,
   output logic                flash_mem_read,
   output logic [ADDR_W-1:0]   flash_mem_address,
   output logic [3:0]          flash_mem_byteenable,
   input  logic                flash_mem_waitrequest,
   input  logic [DATA_W-1:0]   flash_mem_readdata,
   input  logic                flash_mem_readdatavalid,
   output logic                busy,
   output logic                timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_q, last_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rvalid_q, rvalid_d;
   logic                err_q, err_d;

   logic                gnt_valid;
   logic                gnt_idx;
   logic [ADDR_W-1:0]   addr_sel;
   logic                accept;

   rr_pick2 u_pick (
      .req_i        (req_read),
      .last_grant_i (last_q),
      .gnt_valid_o  (gnt_valid),
      .gnt_idx_o    (gnt_idx)
   );

   assign addr_sel = gnt_idx ? req_address[2*ADDR_W-1:ADDR_W]
                             : req_address[ADDR_W-1:0];
   assign accept   = (state_q == ISSUE) & ~flash_mem_waitrequest;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         addr_q   <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      rvalid_d = '0;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               grant_d = gnt_idx;
               addr_d  = addr_sel;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!flash_mem_waitrequest) begin
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            // valid beats the timeout when both land together
            if (flash_mem_readdatavalid) begin
               rdata_d  = flash_mem_readdata;
               rvalid_d = onehot2(grant_q);
               last_d   = grant_q;
               state_d  = IDLE;
            end else if (cnt_q == CNT_LIM) begin
               err_d   = 1'b1;
               last_d  = grant_q;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      flash_mem_read       = (state_q == ISSUE);
      flash_mem_address    = addr_q;
      flash_mem_byteenable = BYTEEN_ALL;
      req_waitrequest      = accept ? ~onehot2(grant_q) : 2'b11;
      req_readdata         = rdata_q;
      req_readdatavalid    = rvalid_q;
      busy                 = (state_q != IDLE);
      timeout_err          = err_q;
   end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: flash model, requester agents, an independent
// arbitration reference and a per-requester data scoreboard.
module tb_flash_read_arbiter;

   localparam int AW = 23;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req_read = '0;
   logic [AW-1:0] addr0 = '0;
   logic [AW-1:0] addr1 = '0;
   logic [2*AW-1:0] req_address;
   logic [1:0]    req_waitrequest;
   logic [DW-1:0] req_readdata;
   logic [1:0]    req_readdatavalid;
   logic          flash_mem_read;
   logic [AW-1:0] flash_mem_address;
   logic [3:0]    flash_mem_byteenable;
   logic          fwait = 1'b1;
   logic          fvalid = 1'b0;
   logic [DW-1:0] fdata = '0;
   logic          busy;
   logic          timeout_err;

   assign req_address = {addr1, addr0};
   always #5 clk = ~clk;

   flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .req_read                (req_read),
      .req_address             (req_address),
      .req_waitrequest         (req_waitrequest),
      .req_readdata            (req_readdata),
      .req_readdatavalid       (req_readdatavalid),
      .flash_mem_read          (flash_mem_read),
      .flash_mem_address       (flash_mem_address),
      .flash_mem_byteenable    (flash_mem_byteenable),
      .flash_mem_waitrequest   (fwait),
      .flash_mem_readdata      (fdata),
      .flash_mem_readdatavalid (fvalid),
      .busy                    (busy),
      .timeout_err             (timeout_err)
   );

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0, drops = 0, rv0_cnt = 0, rv1_cnt = 0;
   int rd_hi = 0, wait_cyc = 0;
   int wait_min = 0, wait_max = 0, dly_min = 3, dly_max = 3;
   int drop_pct = 0, spur_pct = 0;
   bit fixed_en = 1'b0;
   logic [DW-1:0] fixed_data = '0;
   bit auto_drop = 1'b1;
   bit spur_once = 1'b0;

   bit pend = 1'b0;
   int dcnt = 0, wcnt = 0, quiet = 0;
   logic [DW-1:0] pend_data = '0;
   logic [DW-1:0] last_data = '0;
   logic [AW-1:0] last_acc_addr = '0;
   bit exp_err = 1'b0;
   bit tb_last = 1'b1;
   bit drop_g = 1'b0;
   logic [DW-1:0] exp0[$];
   logic [DW-1:0] exp1[$];
   bit gq[$];
   logic [AW-1:0] addr_log[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      if (fixed_en) return fixed_data;
      return ({9'h0, a} * 32'h0000_9E37) ^ 32'h5A5A_0F0F;
   endfunction

   // flash IP model plus the arbitration reference
   always begin : flash_model
      bit g, acc, drq;
      logic [1:0] acc_r;
      @(negedge clk);
      drq = 1'b0;
      if (rst) begin
         exp0.delete();
         exp1.delete();
         gq.delete();
         tb_last = 1'b1;
         exp_err = 1'b0;
         quiet   = 0;
      end else begin
         acc   = flash_mem_read & ~fwait;
         acc_r = req_read & ~req_waitrequest;
         if (flash_mem_read) begin
            rd_hi++;
            if (gq.size() > 0)
               chk("issue_addr", 64'(flash_mem_address),
                   64'(gq[0] ? addr1 : addr0));
         end
         if (busy && !flash_mem_read) wait_cyc++;
         if (acc) begin
            g = acc_r[1];
            chk("acc_onehot", 64'(acc_r), 64'(g ? 2'b10 : 2'b01));
            if (gq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL grant: got accept %0b expected no grant", acc_r);
            end else begin
               chk("grant", 64'(g), 64'(gq.pop_front()));
            end
            chk("flash_addr", 64'(flash_mem_address), 64'(g ? addr1 : addr0));
            acc_cnt++;
            last_acc_addr = flash_mem_address;
            addr_log.push_back(flash_mem_address);
            drq    = auto_drop;
            drop_g = g;
            if ($urandom_range(99) < drop_pct) begin
               drops++;
               exp_err = 1'b1;
               quiet   = TO + 4;
            end else begin
               pend      = 1'b1;
               dcnt      = $urandom_range(dly_max, dly_min);
               pend_data = data_of(g ? addr1 : addr0);
               if (g) exp1.push_back(pend_data);
               else   exp0.push_back(pend_data);
            end
         end else begin
            chk("wreq_idle", 64'(acc_r), 64'(0));
         end
         if (!busy && req_read != 2'b00) begin
            g = (req_read == 2'b11) ? ~tb_last : req_read[1];
            gq.push_back(g);
            tb_last = g;
         end
      end
      @(posedge clk);
      #1;
      if (drq) req_read[drop_g] = 1'b0;
      fvalid = 1'b0;
      if (pend) begin
         dcnt--;
         if (dcnt <= 0) begin
            fvalid = 1'b1;
            fdata  = pend_data;
            pend   = 1'b0;
         end
      end else if (quiet > 0) begin
         quiet--;
      end else if (spur_once || $urandom_range(99) < spur_pct) begin
         fvalid    = 1'b1;
         fdata     = 32'h1234_5678;
         spur_once = 1'b0;
      end
      if (!flash_mem_read) begin
         wcnt  = $urandom_range(wait_max, wait_min);
         fwait = 1'($urandom_range(1, 0));
      end else if (wcnt > 0) begin
         fwait = 1'b1;
         wcnt--;
      end else begin
         fwait = 1'b0;
      end
   end

   always @(negedge clk) begin : monitor
      logic [DW-1:0] e;
      if (!rst) begin
         chk("rv_excl", 64'(req_readdatavalid != 2'b11), 64'(1));
         for (int i = 0; i < 2; i++) begin
            if (req_readdatavalid[i]) begin
               if ((i == 0 && exp0.size() == 0) ||
                   (i == 1 && exp1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL rv%0d: got pulse data %0h expected none",
                           i, req_readdata);
               end else begin
                  e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                  chk("rdata", 64'(req_readdata), 64'(e));
                  last_data = e;
                  if (i == 0) rv0_cnt++;
                  else        rv1_cnt++;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int target, input int budget);
      int n;
      n = 0;
      while (acc_cnt < target && n < budget) begin
         tick(1);
         n++;
      end
      if (acc_cnt < target) begin
         checks++;
         errors++;
         $display("FAIL wait_acc: got %0d accepts expected %0d", acc_cnt, target);
      end
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      n = 0;
      tick(1);
      while (n < budget && (busy || pend || exp0.size() != 0 ||
             exp1.size() != 0 || gq.size() != 0 || req_read != 2'b00)) begin
         tick(1);
         n++;
      end
      chk("drain", 64'(busy || pend || exp0.size() != 0 ||
          exp1.size() != 0 || gq.size() != 0), 64'(0));
   endtask

   task automatic do_reset();
      req_read = 2'b00;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wreq"},  64'(req_waitrequest), 64'(2'b11));
      chk({tag, "_rv"},    64'(req_readdatavalid), 64'(0));
      chk({tag, "_rdata"}, 64'(req_readdata), 64'(0));
      chk({tag, "_err"},   64'(timeout_err), 64'(0));
      chk({tag, "_read"},  64'(flash_mem_read), 64'(0));
      chk({tag, "_addr"},  64'(flash_mem_address), 64'(0));
      chk({tag, "_busy"},  64'(busy), 64'(0));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int r0, r1, base, h, w, n, d0;
      rst = 1'b1;
      tick(3);
      @(negedge clk);
      chk_reset_vals("rst0");
      chk("byteen", 64'(flash_mem_byteenable), 64'(4'hF));
      @(posedge clk);
      #1 rst = 1'b0;

      // single read from requester 0
      fixed_en = 1'b1;
      fixed_data = 32'hDEAD_BEEF;
      r0 = rv0_cnt;
      base = acc_cnt;
      addr0 = 23'h10;
      req_read = 2'b01;
      wait_acc(base + 1, 20);
      wait_quiet(40);
      chk("t1_addr", 64'(last_acc_addr), 64'(23'h10));
      chk("t1_acc", 64'(acc_cnt - base), 64'(1));
      chk("t1_rv0", 64'(rv0_cnt - r0), 64'(1));
      chk("t1_rdata", 64'(req_readdata), 64'(32'hDEAD_BEEF));
      chk("t1_busy", 64'(busy), 64'(0));
      fixed_en = 1'b0;

      // both held: strict alternation starting at requester 0
      do_reset();
      dly_min = 1;
      dly_max = 4;
      auto_drop = 1'b0;
      r0 = rv0_cnt;
      r1 = rv1_cnt;
      n = addr_log.size();
      addr0 = 23'h1;
      addr1 = 23'h2;
      req_read = 2'b11;
      wait_acc(acc_cnt + 4, 80);
      req_read = 2'b00;
      auto_drop = 1'b1;
      wait_quiet(40);
      if (addr_log.size() >= n + 4) begin
         chk("t2_a0", 64'(addr_log[n]),   64'(1));
         chk("t2_a1", 64'(addr_log[n+1]), 64'(2));
         chk("t2_a2", 64'(addr_log[n+2]), 64'(1));
         chk("t2_a3", 64'(addr_log[n+3]), 64'(2));
      end
      chk("t2_rv0", 64'(rv0_cnt - r0), 64'(2));
      chk("t2_rv1", 64'(rv1_cnt - r1), 64'(2));

      // waitrequest held for 5 cycles
      wait_min = 5;
      wait_max = 5;
      dly_min = 2;
      dly_max = 2;
      h = rd_hi;
      r1 = rv1_cnt;
      base = acc_cnt;
      addr1 = 23'h3ABCD;
      req_read = 2'b10;
      wait_acc(base + 1, 30);
      wait_quiet(40);
      chk("t3_rdhi", 64'(rd_hi - h), 64'(6));
      chk("t3_addr", 64'(last_acc_addr), 64'(23'h3ABCD));
      chk("t3_rv1", 64'(rv1_cnt - r1), 64'(1));
      wait_min = 0;
      wait_max = 0;

      // timeout, then recovery with a sticky error
      drop_pct = 100;
      w = wait_cyc;
      r0 = rv0_cnt;
      addr0 = 23'h7;
      req_read = 2'b01;
      wait_acc(acc_cnt + 1, 20);
      wait_quiet(60);
      chk("t4_wait", 64'(wait_cyc - w), 64'(TO));
      chk("t4_err", 64'(timeout_err), 64'(1));
      chk("t4_rv0", 64'(rv0_cnt - r0), 64'(0));
      drop_pct = 0;
      addr0 = 23'h8;
      req_read = 2'b01;
      wait_acc(acc_cnt + 1, 20);
      wait_quiet(40);
      chk("t4_rv0b", 64'(rv0_cnt - r0), 64'(1));
      chk("t4_sticky", 64'(timeout_err), 64'(1));

      // reset during WAIT_DATA, late valid ignored
      dly_min = 3;
      dly_max = 3;
      addr0 = 23'h5;
      req_read = 2'b01;
      wait_acc(acc_cnt + 1, 20);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("t5");
      r0 = rv0_cnt;
      tick(6);
      chk("t5_norv", 64'(rv0_cnt - r0), 64'(0));
      n = addr_log.size();
      addr0 = 23'h9;
      addr1 = 23'hA;
      req_read = 2'b11;
      wait_acc(acc_cnt + 2, 40);
      wait_quiet(40);
      if (addr_log.size() >= n + 2) begin
         chk("t5_first", 64'(addr_log[n]), 64'(23'h9));
         chk("t5_second", 64'(addr_log[n+1]), 64'(23'hA));
      end

      // spurious valid while idle
      d0 = rv0_cnt + rv1_cnt;
      spur_once = 1'b1;
      tick(4);
      chk("t6_rdata", 64'(req_readdata), 64'(last_data));
      chk("t6_norv", 64'(rv0_cnt + rv1_cnt - d0), 64'(0));

      // randomized traffic
      do_reset();
      wait_min = 0;
      wait_max = 3;
      dly_min = 1;
      dly_max = 4;
      drop_pct = 3;
      spur_pct = 10;
      base = acc_cnt - drops;
      d0 = rv0_cnt + rv1_cnt;
      for (int c = 0; c < 4000; c++) begin
         tick(1);
         if (!req_read[0] && $urandom_range(99) < 30) begin
            addr0 = AW'($urandom());
            req_read[0] = 1'b1;
         end
         if (!req_read[1] && $urandom_range(99) < 30) begin
            addr1 = AW'($urandom());
            req_read[1] = 1'b1;
         end
      end
      spur_pct = 0;
      n = 0;
      while (req_read != 2'b00 && n < 200) begin
         tick(1);
         n++;
      end
      req_read = 2'b00;
      wait_quiet(200);
      chk("rnd_rv", 64'(rv0_cnt + rv1_cnt - d0), 64'(acc_cnt - drops - base));
      chk("rnd_err", 64'(timeout_err), 64'(exp_err));
      chk("rnd_busy", 64'(busy), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
